// File: rtl/onchip_mem_burst.sv
// rtl/onchip_mem_burst.sv - parametrised single-port on-chip RAM with Avalon-MM burst slave (optional: ONCHIP_MEM_WRITE_PROTECT_EN)
module onchip_mem_burst #(
  parameter int    DATA_W       = 256,
  parameter int    DEPTH        = 4000,
  parameter int    ADDR_W       = 12,
  parameter int    BURST_W      = 4,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [BURST_W-1:0]    burstcount,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  debugaccess,
  input  logic                  clken,
  input  logic                  freeze,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t             state, state_nxt;
  logic               en;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [BURST_W-1:0] rd_cnt, wr_cnt;
  logic [BURST_W-1:0] beats;
  logic               acc_rd, acc_wr;
  logic               rd_issue, wr_beat, wr_take, wr_allow;
  logic [ADDR_W-1:0]  rd_a, wr_a;
  logic [DATA_W-1:0]  rd_word;
  logic               rd_v1;
  logic [DATA_W-1:0]  rd_d1;

  // Sequential address with wrap at the top of the populated range.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

`ifdef ONCHIP_MEM_WRITE_PROTECT_EN
  assign wr_allow = debugaccess;
`else
  logic debugaccess_unused;
  assign debugaccess_unused = debugaccess;
  assign wr_allow = 1'b1;
`endif

  assign en      = clken & ~freeze;
  assign beats   = (burstcount == '0) ? BURST_W'(1) : burstcount;
  assign rd_a    = (state == IDLE) ? address : rd_addr;
  assign wr_a    = (state == IDLE) ? address : wr_addr;
  assign wr_take = wr_beat & in_range(wr_a) & wr_allow;
  assign rd_word = in_range(rd_a) ? mem[rd_a] : '0;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave a burst state when its final beat goes through
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_wr && beats > BURST_W'(1)) begin
          state_nxt = WR_BURST;
        end else if (acc_rd && beats > BURST_W'(1)) begin
          state_nxt = RD_BURST;
        end
      end
      RD_BURST: if (rd_issue && rd_cnt == BURST_W'(1)) state_nxt = IDLE;
      WR_BURST: if (wr_beat && wr_cnt == BURST_W'(1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept decode, beat strobes and waitrequest
  always_comb begin
    acc_rd      = 1'b0;
    acc_wr      = 1'b0;
    rd_issue    = 1'b0;
    wr_beat     = 1'b0;
    waitrequest = 1'b1;
    if (reset_n && en) begin
      case (state)
        IDLE: begin
          waitrequest = 1'b0;
          acc_wr      = chipselect & write;
          acc_rd      = chipselect & read & ~write;
          rd_issue    = acc_rd;
          wr_beat     = acc_wr;
        end
        RD_BURST: begin
          waitrequest = 1'b1;
          rd_issue    = 1'b1;
        end
        WR_BURST: begin
          waitrequest = 1'b0;
          wr_beat     = chipselect & write;
        end
        default: waitrequest = 1'b1;
      endcase
    end
  end

  // Burst address/count tracking; the accept cycle loads from the command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      rd_cnt  <= '0;
      wr_addr <= '0;
      wr_cnt  <= '0;
    end else begin
      if (rd_issue) begin
        rd_addr <= next_addr(rd_a);
        rd_cnt  <= (state == IDLE) ? beats - BURST_W'(1) : rd_cnt - BURST_W'(1);
      end
      if (wr_beat) begin
        wr_addr <= next_addr(wr_a);
        wr_cnt  <= (state == IDLE) ? beats - BURST_W'(1) : wr_cnt - BURST_W'(1);
      end
    end
  end

  // Memory array write with byte lanes; reset never touches contents
  always_ff @(posedge clk) begin
    if (wr_take) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i]) mem[wr_a][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // First read stage: array lookup; holds under stall, flushed by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else if (en) begin
      rd_v1 <= rd_issue;
      if (rd_issue) rd_d1 <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              rd_v2;
    logic [DATA_W-1:0] rd_d2;

    // Optional output register stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else if (en) begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_d1;
      end
    end

    assign readdata      = rd_d2;
    assign readdatavalid = rd_v2 & en;
  end else begin : g_lat1
    assign readdata      = rd_d1;
    assign readdatavalid = rd_v1 & en;
  end

endmodule

// File: tb/tb_onchip_mem_burst.sv
// tb/tb_onchip_mem_burst.sv - self-checking bench for onchip_mem_burst
module tb_onchip_mem_burst;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int BW    = 4;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;
  logic          chipselect, read, write;
  logic [DW-1:0] writedata;
  logic [3:0]    byteenable;
  logic          debugaccess, clken, freeze;
  logic [DW-1:0] readdata;
  logic          readdatavalid, waitrequest;

  onchip_mem_burst #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BURST_W(BW),
    .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .burstcount(burstcount),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess), .clken(clken), .freeze(freeze),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  logic [DW-1:0] wd[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mmem[DEPTH];
  int            m_rd_left = 0, m_rd_addr = 0, m_wr_left = 0, m_wr_addr = 0;
  logic [DW-1:0] pq_d[$];
  int            pq_a[$];
  logic [DW-1:0] exp_rd = '0;

  function automatic int nxt(input int a);
    return (a == DEPTH - 1) ? 0 : (a + 1) % 32;
  endfunction

  function automatic logic [DW-1:0] rdw(input int a);
    return (a < DEPTH) ? mmem[a] : '0;
  endfunction

  task automatic m_write(input int a);
    bit allow;
    allow = 1'b1;
`ifdef ONCHIP_MEM_WRITE_PROTECT_EN
    allow = debugaccess;
`endif
    if (a < DEPTH && allow)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mmem[a][8*i +: 8] = writedata[8*i +: 8];
  endtask

  // Compare DUT outputs against the model every cycle, then advance the model
  always @(negedge clk) begin
    logic          en_m;
    bit            ev, iss;
    logic [DW-1:0] iss_d;
    int            bc;
    if (!reset_n) begin
      m_rd_left = 0; m_wr_left = 0; pq_a.delete(); pq_d.delete(); exp_rd = '0;
    end
    en_m = clken & ~freeze;
    ev = 1'b0;
    foreach (pq_a[i]) if (pq_a[i] == LAT) ev = 1'b1;
    chk("waitrequest", 32'(waitrequest), 32'(!reset_n || !en_m || m_rd_left > 0));
    chk("readdatavalid", 32'(readdatavalid), 32'(ev && en_m));
    chk("readdata", readdata, exp_rd);
    if (readdatavalid === 1'b1) begin
      got.push_back(readdata);
      got_cyc.push_back(cyc);
    end
    if (reset_n && en_m) begin
      iss = 1'b0; iss_d = '0;
      bc = (burstcount == '0) ? 1 : int'(burstcount);
      if (m_rd_left > 0) begin
        iss = 1'b1; iss_d = rdw(m_rd_addr);
        m_rd_left--; m_rd_addr = nxt(m_rd_addr);
      end else if (m_wr_left > 0) begin
        if (chipselect && write) begin
          m_write(m_wr_addr); m_wr_left--; m_wr_addr = nxt(m_wr_addr);
        end
      end else if (chipselect && write) begin
        m_write(int'(address)); m_wr_left = bc - 1; m_wr_addr = nxt(int'(address));
      end else if (chipselect && read) begin
        iss = 1'b1; iss_d = rdw(int'(address));
        m_rd_left = bc - 1; m_rd_addr = nxt(int'(address));
      end
      foreach (pq_a[i]) pq_a[i]++;
      if (pq_a.size() > 0 && pq_a[0] > LAT) begin
        void'(pq_a.pop_front()); void'(pq_d.pop_front());
      end
      if (iss) begin pq_a.push_back(1); pq_d.push_back(iss_d); end
      foreach (pq_a[i]) if (pq_a[i] == LAT) exp_rd = pq_d[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    chipselect = 0; read = 0; write = 0; byteenable = '0; debugaccess = 0;
  endtask

  task automatic cmd_wait();
    int k;
    k = 0;
    while (waitrequest !== 1'b0 && k < 50) begin step(); k++; end
    if (waitrequest !== 1'b0) chk("cmd_wait_timeout", 32'(waitrequest), 32'd0);
  endtask

  task automatic wr(input int a, input int n, input logic [3:0] be, input logic dbg, input int gap);
    cmd_wait();
    for (int i = 0; i < n; i++) begin
      if (i == gap) begin chipselect = 1; write = 0; step(); end
      chipselect = 1; write = 1; address = AW'(a); burstcount = BW'(n);
      writedata = wd[i]; byteenable = be; debugaccess = dbg;
      step();
    end
    idle_in();
  endtask

  task automatic rd(input int a, input int n, output int acc_c);
    cmd_wait();
    chipselect = 1; read = 1; address = AW'(a); burstcount = BW'(n);
    acc_c = cyc;
    step();
    idle_in();
    repeat (n + LAT + 2) step();
  endtask

  int acc_c;
  logic [DW-1:0] exp_prot;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; clken = 1; freeze = 0; address = '0; burstcount = '0;
    writedata = '0; idle_in();
    step();
    chk("wait_in_reset", 32'(waitrequest), 32'd1);
    step(); step();
    reset_n = 1;
    step();

    // word 5 = A5.., then reset: contents survive
    wd[0] = 32'hA5A5_A5A5;
    wr(5, 1, 4'hF, 1, -1);
    reset_n = 0; step(); step(); reset_n = 1; step();
    got.delete(); got_cyc.delete();
    rd(5, 1, acc_c);
    chk("single_count", 32'(got.size()), 32'd1);
    chk("single_data", got[0], 32'hA5A5_A5A5);
    chk("single_latency", 32'(got_cyc[0] - acc_c), 32'(LAT));

    // wrap burst 14,15,0,1
    wd[0] = 1; wd[1] = 2; wd[2] = 3; wd[3] = 4;
    wr(14, 4, 4'hF, 1, -1);
    got.delete(); got_cyc.delete();
    rd(14, 4, acc_c);
    chk("wrap_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("wrap_data", got[i], 32'(i + 1));
    chk("wrap_contig", 32'(got_cyc[3] - got_cyc[0]), 32'd3);

    // byte enables
    wd[0] = 32'hFFFF_FFFF; wr(3, 1, 4'hF, 1, -1);
    wd[0] = 32'h0000_0000; wr(3, 1, 4'h1, 1, -1);
    got.delete(); got_cyc.delete();
    rd(3, 1, acc_c);
    chk("byteen_data", got[0], 32'hFFFF_FF00);

    // fill 0..7 with a write gap mid-burst
    for (int i = 0; i < 8; i++) wd[i] = 32'h100 + 32'(i);
    wr(0, 8, 4'hF, 1, 4);

    // 8-beat read with a 3-cycle clken stall
    got.delete(); got_cyc.delete();
    cmd_wait();
    chipselect = 1; read = 1; address = '0; burstcount = 4'd8; acc_c = cyc;
    step(); idle_in();
    step(); step();
    clken = 0; repeat (3) step(); clken = 1;
    repeat (12) step();
    chk("stall_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("stall_data", got[i], 32'h100 + 32'(i));
    chk("stall_span", 32'(got_cyc[7] - got_cyc[0]), 32'd10);

    // freeze stalls a 2-beat read
    got.delete(); got_cyc.delete();
    cmd_wait();
    chipselect = 1; read = 1; address = AW'(4); burstcount = 4'd2;
    step(); idle_in();
    freeze = 1; step(); step(); freeze = 0;
    repeat (6) step();
    chk("freeze_count", 32'(got.size()), 32'd2);
    chk("freeze_d0", got[0], 32'h104);
    chk("freeze_d1", got[1], 32'h105);

    // reset after third beat of an 8-beat read
    got.delete(); got_cyc.delete();
    cmd_wait();
    chipselect = 1; read = 1; address = '0; burstcount = 4'd8;
    step(); idle_in();
    for (int k = 0; k < 30 && got.size() < 3; k++) step();
    reset_n = 0; step(); step(); reset_n = 1;
    repeat (6) step();
    chk("reset_beats", 32'(got.size()), 32'd3);
    rd(0, 1, acc_c);
    chk("reset_reread", got[3], 32'h100);

    // read and write together: write wins, no read beat
    got.delete(); got_cyc.delete();
    cmd_wait();
    chipselect = 1; read = 1; write = 1; address = AW'(10); burstcount = 4'd1;
    writedata = 32'h77; byteenable = 4'hF; debugaccess = 1;
    step(); idle_in();
    repeat (4) step();
    chk("rw_no_valid", 32'(got.size()), 32'd0);
    rd(10, 1, acc_c);
    chk("rw_write_won", got[0], 32'h77);

    // out of range
    got.delete(); got_cyc.delete();
    rd(16, 1, acc_c);
    chk("oor_count", 32'(got.size()), 32'd1);
    chk("oor_zero", got[0], 32'h0);
    wd[0] = 32'hDEAD_BEEF; wr(16, 1, 4'hF, 1, -1);
    rd(0, 1, acc_c);
    chk("oor_word0", got[1], 32'h100);

    // write protect
    wd[0] = 32'h1111_1111; wr(9, 1, 4'hF, 1, -1);
    wd[0] = 32'h2222_2222; wr(9, 1, 4'hF, 0, -1);
    got.delete(); got_cyc.delete();
    rd(9, 1, acc_c);
`ifdef ONCHIP_MEM_WRITE_PROTECT_EN
    exp_prot = 32'h1111_1111;
`else
    exp_prot = 32'h2222_2222;
`endif
    chk("protect_dbg0", got[0], exp_prot);
    wd[0] = 32'h3333_3333; wr(9, 1, 4'hF, 1, -1);
    rd(9, 1, acc_c);
    chk("protect_dbg1", got[1], 32'h3333_3333);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
